// File: rtl/perf_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_ctrl
// Description : Sequences a bank of NCNT event/cycle counters through START,
//               STOP, CLEAR and SNAP commands. All counting freezes while the
//               CPU is halted. The counters are read only through the
//               snapshot bank, one register at a time.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               halt           - CPU halt level, sampled every cycle
//               ev[NCNT]       - per-counter increment strobes
//               cmd_valid/op   - command request (00 START 01 STOP 10 CLEAR 11 SNAP)
//               cmd_ready      - low only while the clear sequence runs
//               sel            - snapshot register select
//               rdata          - registered snapshot[sel]
//               running        - registered, high in RUN
//               ovf[NCNT]      - sticky per-counter wrap flags
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_ctrl #(
    parameter int WIDTH = 32,
    parameter int NCNT  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    halt,
    input  logic [NCNT-1:0]         ev,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd_op,
    output logic                    cmd_ready,
    input  logic [$clog2(NCNT)-1:0] sel,
    output logic [WIDTH-1:0]        rdata,
    output logic                    running,
    output logic [NCNT-1:0]         ovf
);

    localparam int              c_IW       = $clog2(NCNT);
    localparam logic [1:0]      c_OP_START = 2'b00;
    localparam logic [1:0]      c_OP_STOP  = 2'b01;
    localparam logic [1:0]      c_OP_CLEAR = 2'b10;
    localparam logic [1:0]      c_OP_SNAP  = 2'b11;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(NCNT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_CLR    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [c_IW-1:0]  r_clr_idx;
    logic [WIDTH-1:0] r_cnt  [NCNT];
    logic [WIDTH-1:0] r_snap [NCNT];
    logic [NCNT-1:0]  r_ovf;
    logic [WIDTH-1:0] r_rdata;
    logic             r_running;

    logic             w_accept;
    logic             w_snap;
    logic             w_clr_last;

    assign cmd_ready  = (r_state != S_CLR);
    assign w_accept   = cmd_valid & cmd_ready;
    // SNAP is honoured in every accepting state, even when halt wins the
    // state transition in the same cycle.
    assign w_snap     = w_accept & (cmd_op == c_OP_SNAP);
    assign w_clr_last = (r_state == S_CLR) && (r_clr_idx == c_LAST_IDX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_next;
            // Registered from the next state so running lines up with RUN.
            r_running <= (w_next == S_RUN);
            // Index walks 0..NCNT-1 while clearing and wraps back to 0.
            if (r_state == S_CLR) begin
                r_clr_idx <= r_clr_idx + c_IW'(1);
            end else begin
                r_clr_idx <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_RUN: begin
                // halt overrides any command arriving in the same cycle.
                if (halt) begin
                    w_next = S_HALTED;
                end else if (w_accept) begin
                    case (cmd_op)
                        c_OP_START: w_next = S_RUN;
                        c_OP_STOP:  w_next = S_IDLE;
                        c_OP_CLEAR: w_next = S_CLR;
                        default:    w_next = r_state;
                    endcase
                end
            end
            S_HALTED: begin
                // Only CLEAR leaves HALTED, whatever the halt level.
                if (w_accept && (cmd_op == c_OP_CLEAR)) begin
                    w_next = S_CLR;
                end
            end
            S_CLR: begin
                if (w_clr_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counter bank, overflow flags and snapshot bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= '0;
            for (int i = 0; i < NCNT; i++) begin
                r_cnt[i]  <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if ((r_state == S_RUN) && ev[i]) begin
                    r_cnt[i] <= r_cnt[i] + WIDTH'(1);
                    if (&r_cnt[i]) begin
                        r_ovf[i] <= 1'b1;
                    end
                end else if ((r_state == S_CLR) && (r_clr_idx == c_IW'(i))) begin
                    r_cnt[i] <= '0;
                end
                // Snapshot takes the pre-increment value of this cycle.
                if (w_snap) begin
                    r_snap[i] <= r_cnt[i];
                end
            end
            if (w_clr_last) begin
                r_ovf <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Readout register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_snap[sel];
        end
    end

    assign rdata   = r_rdata;
    assign running = r_running;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_counter_ctrl
// Description : Self-checking bench for perf_counter_ctrl (WIDTH=4, NCNT=4
//               so wraps happen quickly). A cycle-level behavioural model
//               predicts cmd_ready, running, ovf and rdata; a compare process
//               checks them every falling edge. Directed scenarios pin both
//               DUT and model to hand-computed values, then random traffic
//               (including asynchronous reset pulses) runs against the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_counter_ctrl;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SW = $clog2(N);

    localparam logic [1:0] c_START = 2'b00;
    localparam logic [1:0] c_STOP  = 2'b01;
    localparam logic [1:0] c_CLEAR = 2'b10;
    localparam logic [1:0] c_SNAP  = 2'b11;

    localparam int c_M_IDLE = 0;
    localparam int c_M_RUN  = 1;
    localparam int c_M_HALT = 2;
    localparam int c_M_CLR  = 3;

    logic          clk;
    logic          rst;
    logic          halt;
    logic [N-1:0]  ev;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic          cmd_ready;
    logic [SW-1:0] sel;
    logic [W-1:0]  rdata;
    logic          running;
    logic [N-1:0]  ovf;

    int n_chk  = 0;
    int n_fail = 0;

    perf_counter_ctrl #(.WIDTH(W), .NCNT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .ev        (ev),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .sel       (sel),
        .rdata     (rdata),
        .running   (running),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: counters as plain integers mod 2**W
    // ------------------------------------------------------------------
    int         m_st   = c_M_IDLE;
    int         m_ci   = 0;
    int         m_cnt  [N];
    int         m_snap [N];
    logic [N-1:0] m_ovf = '0;
    int         m_rdata = 0;

    initial begin : model
        bit acc;
        int nst;
        int v;
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_snap[i] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_st = c_M_IDLE; m_ci = 0; m_ovf = '0; m_rdata = 0;
                for (int i = 0; i < N; i++) begin
                    m_cnt[i]  = 0;
                    m_snap[i] = 0;
                end
            end else begin
                acc     = cmd_valid && (m_st != c_M_CLR);
                m_rdata = m_snap[sel];
                if (acc && cmd_op == c_SNAP) begin
                    for (int i = 0; i < N; i++) m_snap[i] = m_cnt[i];
                end
                nst = m_st;
                if (m_st == c_M_RUN) begin
                    for (int i = 0; i < N; i++) begin
                        if (ev[i]) begin
                            v = m_cnt[i] + 1;
                            if (v == (1 << W)) begin
                                v = 0;
                                m_ovf[i] = 1'b1;
                            end
                            m_cnt[i] = v;
                        end
                    end
                end
                if (m_st == c_M_IDLE || m_st == c_M_RUN) begin
                    if (halt) nst = c_M_HALT;
                    else if (acc && cmd_op == c_START) nst = c_M_RUN;
                    else if (acc && cmd_op == c_STOP)  nst = c_M_IDLE;
                    else if (acc && cmd_op == c_CLEAR) nst = c_M_CLR;
                end else if (m_st == c_M_HALT) begin
                    if (acc && cmd_op == c_CLEAR) nst = c_M_CLR;
                end else begin
                    m_cnt[m_ci] = 0;
                    if (m_ci == N - 1) begin
                        m_ovf = '0;
                        nst   = c_M_IDLE;
                    end
                    m_ci = m_ci + 1;
                end
                if (nst == c_M_CLR && m_st != c_M_CLR) m_ci = 0;
                m_st = nst;
            end
        end
    end

    // Compare process: outputs are stable mid-cycle.
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("cyc_cmd_ready", cmd_ready, (m_st != c_M_CLR) ? 1 : 0);
            chk("cyc_running",   running,   (m_st == c_M_RUN) ? 1 : 0);
            chk("cyc_ovf",       ovf,       m_ovf);
            chk("cyc_rdata",     rdata,     m_rdata);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
    endtask

    task automatic do_clear();
        cmd(c_CLEAR); tick();
        cmd_valid = 1'b0; ev = '0;
        repeat (N) tick();
    endtask

    initial begin : stim
        rst = 1'b1; halt = 1'b0; ev = '0; cmd_valid = 1'b0; cmd_op = 2'b00; sel = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ready",   cmd_ready, 1);
        chk("rst_running", running,   0);
        chk("rst_ovf",     ovf,       0);
        chk("rst_rdata",   rdata,     0);

        // Cycle count: START (its event ignored), 10 events incl. STOP cycle.
        cmd(c_START); ev = 4'b0001; tick();
        cmd_valid = 1'b0; repeat (9) tick();
        chk("s1_running", running, 1);
        cmd(c_STOP); tick();
        ev = '0; cmd(c_SNAP); tick();
        cmd_valid = 1'b0; sel = '0; tick();
        chk("s1_rdata0",       rdata,   10);
        chk("s1_model_rdata0", m_rdata, 10);
        for (int s = 1; s < N; s++) begin
            sel = SW'(s); tick();
            chk("s1_rdata_other", rdata, 0);
        end

        // SNAP in RUN at count 7, second SNAP three cycles later.
        do_clear();
        cmd(c_START); tick();
        cmd_valid = 1'b0; ev = 4'b0001; repeat (7) tick();
        cmd(c_SNAP); sel = '0; tick();
        cmd_valid = 1'b0; tick();
        chk("s4_rdata_first", rdata, 7);
        tick();
        cmd(c_SNAP); tick();
        cmd_valid = 1'b0; tick();
        chk("s4_rdata_second",   rdata,   10);
        chk("s4_model_second",   m_rdata, 10);

        // Halt freezes counter 2 at its halt-cycle value.
        do_clear();
        cmd(c_START); tick();
        cmd_valid = 1'b0; ev = 4'b0100; repeat (3) tick();
        halt = 1'b1; tick();
        halt = 1'b0; cmd(c_START); repeat (5) tick();
        cmd_valid = 1'b0; ev = '0;
        chk("s2_running", running,   0);
        chk("s2_ready",   cmd_ready, 1);
        cmd(c_SNAP); sel = SW'(2); tick();
        cmd_valid = 1'b0; tick();
        chk("s2_rdata2",     rdata,   4);
        chk("s2_still_halt", running, 0);

        // Wrap: 17 events on counter 1 with 4-bit counters.
        do_clear();
        chk("s3_after_clear_running", running, 0);
        cmd(c_START); tick();
        cmd_valid = 1'b0; ev = 4'b0010; repeat (17) tick();
        ev = '0;
        chk("s3_ovf",       ovf,   4'b0010);
        chk("s3_model_ovf", m_ovf, 4'b0010);
        cmd(c_SNAP); sel = SW'(1); tick();
        cmd_valid = 1'b0; tick();
        chk("s3_rdata1", rdata, 1);

        // CLEAR held valid across the clear sequence.
        cmd(c_CLEAR); tick();
        for (int k = 0; k < N; k++) begin
            chk("s5_ready_low", cmd_ready, 0);
            tick();
        end
        chk("s5_ready_high", cmd_ready, 1);
        chk("s5_ovf_clear",  ovf,       0);
        tick();
        chk("s5_second_clear", cmd_ready, 0);
        cmd_valid = 1'b0;
        repeat (N) tick();
        chk("s5_idle_ready", cmd_ready, 1);
        cmd(c_SNAP); tick();
        cmd_valid = 1'b0; tick();
        chk("s5_rdata1_zero", rdata, 0);

        // Asynchronous reset in the middle of the clear sequence.
        cmd(c_START); tick();
        cmd_valid = 1'b0; ev = 4'b1111; repeat (3) tick();
        cmd(c_SNAP); tick();
        cmd(c_STOP); tick();
        cmd_valid = 1'b0; ev = '0; sel = '0; tick();
        chk("s6_rdata_pre", rdata, 3);
        cmd(c_CLEAR); tick();
        cmd_valid = 1'b0; tick(); tick();
        #1 rst = 1'b1;
        #1;
        chk("s6_ready",   cmd_ready, 1);
        chk("s6_running", running,   0);
        chk("s6_rdata",   rdata,     0);
        chk("s6_ovf",     ovf,       0);
        #1 rst = 1'b0;
        tick();
        chk("s6_idle_ready", cmd_ready, 1);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_op    = 2'($urandom_range(0, 3));
            ev        = N'($urandom);
            sel       = SW'($urandom_range(0, N - 1));
            halt      = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end
        cmd_valid = 1'b0; halt = 1'b0; ev = '0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
